multicycle_adder: RTL and testbench
===================================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL take parameter CHUNK, default 4: bits added per clock cycle.
REQ-003 The block SHALL require WIDTH % CHUNK == 0 and CHUNK >= 1, and SHALL fail elaboration otherwise.
REQ-004 The block SHALL define NCH = WIDTH/CHUNK as a derived local constant.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-009 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-010 The block SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-011 The block SHALL have port sub, input, 1 bit: 1 selects a - b, 0 selects a + b + cin.
REQ-012 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-015 The block SHALL have port cout, output, 1 bit: final carry (in sub mode, 1 = no borrow).
REQ-016 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-017 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-018 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-019 IDLE: on in_valid=1 at a rising edge (the accept edge), the block SHALL:
- latch a, and b (or ~b when sub=1);
- set the internal carry to cin in add mode, or 1 in sub mode;
- clear the chunk index;
- go to CALC.
REQ-020 CALC: each cycle SHALL add chunk [idx*CHUNK +: CHUNK] of the latched operands with the carry, write that sum chunk, register the chunk carry-out, and increment idx.
REQ-021 After chunk NCH-1, the block SHALL go to DONE, with out_valid high starting NCH cycles after the accept edge.
REQ-022 cout SHALL equal the carry out of bit WIDTH-1.
REQ-023 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-024 DONE: sum, cout and ovf SHALL hold stable until out_ready=1 at an edge, and the block SHALL then return to IDLE.
REQ-025 There SHALL be no same-cycle turnaround: the earliest next accept is one cycle after the result handshake.
REQ-026 in_valid and operand changes outside the IDLE accept edge SHALL be ignored and SHALL NOT affect the result in progress.
REQ-027 In DONE, out_ready=0 SHALL hold state indefinitely with no loss of the result.
REQ-028 sum SHALL NOT be guaranteed valid in CALC; consumers SHALL qualify sum with out_valid.
REQ-029 With CHUNK = WIDTH, the block SHALL complete in one CALC cycle.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, force:
- state to IDLE and idx to 0;
- sum, cout, ovf and out_valid to 0;
- in_ready to 1.
REQ-031 Reset asserted in CALC or DONE SHALL abort the operation with no result emitted after release.
REQ-032 After rst_n rises, an operation SHALL be accepted at the first clock edge with in_valid=1.

Structure
REQ-033 Package adder_pkg SHALL hold the state enum typedef (IDLE, CALC, DONE) and the default WIDTH and CHUNK constants.
REQ-034 Sub-module chunk_adder SHALL be a CHUNK-bit ripple adder built from the existing fullAdder cell.
- outputs: chunk sum, carry-out, and carry into its MSB (for ovf);
- instantiated once; the FSM selects its operand slice by idx.

Verification (WIDTH=16, CHUNK=4)
REQ-035 a=0x00FF, b=0x0001, sub=0, cin=0 -> sum=0x0100, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
REQ-036 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; and a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
REQ-037 sub=1 with a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; and a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-038 out_ready held 0 for 10 cycles in DONE, with in_valid=1 and changing operands -> sum, cout and ovf stable, in_ready=0, and the next accept happens only after the handshake.
REQ-039 rst_n pulsed low during CALC at idx=2 -> out_valid=0, sum=0 and in_ready=1 with no clock; a fresh 0x1234+0x1111 then yields 0x2345.
REQ-040 Randomised regression of 1000 operations against a reference model, with random in_valid/out_ready gaps, also rerun with CHUNK=1 and CHUNK=16 -> zero mismatches.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the multicycle adder.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : adder_pkg

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             co_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = ci_i;

  // Ripple chain of full adder cells.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fullAdder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (carry[i]),
      .s_o  (sum_o[i]),
      .co_o (carry[i+1])
    );
  end

  assign co_o   = carry[CHUNK];
  assign cmsb_o = carry[CHUNK-1];

endmodule : chunk_adder

// File: rtl/fullAdder.sv
// One-bit full adder cell.
module fullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule : fullAdder

// File: rtl/multicycle_adder.sv
// Handshaked adder/subtractor that ripples CHUNK bits per clock through one shared chunk adder.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNK_NZ = (CHUNK == 0) ? 1 : CHUNK;
  localparam int unsigned NCH      = WIDTH / CHUNK_NZ;
  localparam int unsigned IDX_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCH - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK_NZ{1'b1}});

  // Reject parameter sets that do not tile the word exactly.
  if ((CHUNK < 1) || ((WIDTH % CHUNK_NZ) != 0)) begin : g_bad_params
    $error("multicycle_adder: CHUNK must be >= 1 and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      sh;
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_out, c_msb;

  // Bit offset of the chunk being processed.
  assign sh      = 32'(idx_q) * CHUNK;
  assign a_chunk = CHUNK'(a_q >> sh);
  assign b_chunk = CHUNK'(b_q >> sh);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_i    (a_chunk),
    .b_i    (b_chunk),
    .ci_i   (carry_q),
    .sum_o  (s_chunk),
    .co_o   (c_out),
    .cmsb_o (c_msb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: latch operands on accept, fold in one chunk per CALC cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      CALC: begin
        sum_d   = (sum_q & ~(CHUNK_MASK << sh)) | (WIDTH'(s_chunk) << sh);
        carry_d = c_out;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          cout_d = c_out;
          ovf_d  = c_msb ^ c_out;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule : multicycle_adder

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: directed cases at CHUNK=4, random regression at CHUNK=4/1/16.
module tb_multicycle_adder;

  localparam int unsigned NOPS = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          rand_go = 1'b0;
  logic [17:0] sb_q[$];
  logic [17:0] mon_e;
  logic [17:0] hexp;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: {ovf, cout, sum}; overflow from operand/result sign rule.
  function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb_,
                                        input logic tcin, input logic tsub);
    logic [15:0] op_b;
    logic [16:0] full;
    logic        v;
    op_b = tsub ? ~tb_ : tb_;
    full = {1'b0, ta} + {1'b0, op_b} + {16'd0, (tsub ? 1'b1 : tcin)};
    v    = (ta[15] == op_b[15]) && (full[15] != ta[15]);
    return {v, full[16], full[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result monitor: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(sb_q.size()), 32'(1));
      end else begin
        mon_e = sb_q.pop_front();
        chk("sum",  32'(sum),  32'(mon_e[15:0]));
        chk("cout", 32'(cout), 32'(mon_e[16]));
        chk("ovf",  32'(ovf),  32'(mon_e[17]));
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                      input logic tsub, input bit chk_lat);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("send_ready", 32'(in_ready), 32'(1));
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    sb_q.push_back(model(ta, tb_, tcin, tsub));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    if (chk_lat) begin
      chk("acc_in_ready", 32'(in_ready), 32'(0));
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk); #1;
        chk("latency", 32'(out_valid), 32'(k == 4));
      end
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 32'(sb_q.size()), 32'(0));
  endtask

  // Directed sequence, then random regression on the CHUNK=4 instance.
  initial begin
    int acc, cyc, n;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum",       32'(sum),       32'(0));
    chk("rst_cout",      32'(cout),      32'(0));
    chk("rst_ovf",       32'(ovf),       32'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1); wait_empty();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1); wait_empty();
    send(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0); wait_empty();
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0); wait_empty();
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0); wait_empty();
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0); wait_empty();
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0); wait_empty();

    // Hold in DONE for 10 cycles while new operands are offered.
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0);
    hexp = model(16'h1234, 16'h4321, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("hold_reach_done", 32'(out_valid), 32'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_sum",      32'(sum),       32'(hexp[15:0]));
      chk("hold_cout",     32'(cout),      32'(hexp[16]));
      chk("hold_ovf",      32'(ovf),       32'(hexp[17]));
      chk("hold_in_ready", 32'(in_ready),  32'(0));
      chk("hold_valid",    32'(out_valid), 32'(1));
    end
    a = 16'hA5A5; b = 16'h0F0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_ready", 32'(in_ready),  32'(1));
    chk("post_hs_valid", 32'(out_valid), 32'(0));
    sb_q.push_back(model(16'hA5A5, 16'h0F0F, 1'b1, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("next_acc", 32'(in_ready), 32'(0));
    wait_empty();

    // Reset in the middle of CALC (idx = 2).
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_sum",       32'(sum),       32'(0));
    chk("abort_in_ready",  32'(in_ready),  32'(1));
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_result", 32'(out_valid), 32'(0));
    end
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    chk("fresh_model", 32'(sb_q[0][15:0]), 32'(16'h2345));
    wait_empty();

    // Random regression with gaps and busy-time input noise.
    rand_go = 1'b1;
    acc = 0; cyc = 0;
    while ((acc < NOPS || sb_q.size() != 0) && cyc < 40000) begin
      @(posedge clk); #1; cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc < NOPS) begin
        in_valid = 1'($urandom);
        a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        b   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        if (in_valid && in_ready) begin
          sb_q.push_back(model(a, b, cin, sub));
          acc++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("c4_accepts", 32'(acc), 32'(NOPS));
    chk("c4_drain",   32'(sb_q.size()), 32'(0));

    wait (g_alt[0].done && g_alt[1].done);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Same regression on CHUNK=1 and CHUNK=16 instances.
  for (genvar g = 0; g < 2; g++) begin : g_alt
    localparam int unsigned CH = (g == 0) ? 1 : 16;
    logic        iv, ir, ov, ordy, gcin, gsub, gco, gof;
    logic [15:0] ga, gb, gs;
    logic [17:0] q[$];
    logic [17:0] e;
    bit          done = 1'b0;

    multicycle_adder #(.WIDTH(16), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (ga),
      .b         (gb),
      .cin       (gcin),
      .sub       (gsub),
      .out_valid (ov),
      .out_ready (ordy),
      .sum       (gs),
      .cout      (gco),
      .ovf       (gof)
    );

    always @(negedge clk) begin
      if (rst_n && ov && ordy) begin
        if (q.size() == 0) begin
          chk($sformatf("c%0d_sb_empty", CH), 32'(q.size()), 32'(1));
        end else begin
          e = q.pop_front();
          chk($sformatf("c%0d_sum", CH),  32'(gs),  32'(e[15:0]));
          chk($sformatf("c%0d_cout", CH), 32'(gco), 32'(e[16]));
          chk($sformatf("c%0d_ovf", CH),  32'(gof), 32'(e[17]));
        end
      end
    end

    initial begin
      int acc, cyc, n;
      iv = 1'b0; ordy = 1'b0; ga = '0; gb = '0; gcin = 1'b0; gsub = 1'b0;
      wait (rand_go);
      @(posedge clk); #1;
      // Latency: NCH cycles from accept to out_valid.
      ga = 16'h7FFF; gb = 16'h0001; gcin = 1'b0; gsub = 1'b0; iv = 1'b1;
      q.push_back(model(16'h7FFF, 16'h0001, 1'b0, 1'b0));
      @(posedge clk); #1;
      iv = 1'b0;
      n = 0;
      while (!ov && n < 100) begin
        @(posedge clk); #1; n++;
      end
      chk($sformatf("c%0d_latency", CH), 32'(n), 32'(16 / CH));
      ordy = 1'b1;
      acc = 0; cyc = 0;
      while ((acc < NOPS || q.size() != 0) && cyc < 60000) begin
        @(posedge clk); #1; cyc++;
        ordy = ($urandom_range(0, 3) != 0);
        if (acc < NOPS) begin
          iv   = 1'($urandom);
          ga   = 16'($urandom); gb = 16'($urandom);
          gcin = 1'($urandom);  gsub = 1'($urandom);
          if (iv && ir) begin
            q.push_back(model(ga, gb, gcin, gsub));
            acc++;
          end
        end else begin
          iv = 1'b0;
        end
      end
      chk($sformatf("c%0d_accepts", CH), 32'(acc), 32'(NOPS));
      chk($sformatf("c%0d_drain", CH),   32'(q.size()), 32'(0));
      done = 1'b1;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule : tb_multicycle_adder
